// File: rtl/buttons_in.sv
// Debounced push-button block with a small word-addressed register bus.
// Optional interrupt support (irq_en register, btn_irq) is enabled by defining BUTTONS_IRQ_EN.
module buttons_in #(
    parameter int NBTN            = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NBTN-1:0] btn_pins,
    input  logic            btn_sel,
    input  logic            btn_we,
    input  logic [1:0]      btn_addr,
    input  logic [31:0]     btn_data_i,
    output logic            btn_ready,
    output logic [31:0]     btn_data_o,
    output logic            btn_irq
);

    localparam logic [23:0]     CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);
    // Synchronizers come out of reset at the released pin level, so a held button debounces from scratch.
    localparam logic [NBTN-1:0] PIN_IDLE = ACTIVE_LOW ? {NBTN{1'b1}} : {NBTN{1'b0}};

    logic [NBTN-1:0] meta_r;
    logic [NBTN-1:0] sync2_r;
    logic [NBTN-1:0] sync_s;
    logic [NBTN-1:0] stable_s;
    logic [NBTN-1:0] stable_d_r;
    logic [NBTN-1:0] events_r;
    logic [NBTN-1:0] events_nxt_s;
    logic [NBTN-1:0] rise_s;
    logic [NBTN-1:0] ev_clr_s;
    logic            ready_r;
    logic [31:0]     data_o_r;
    logic [31:0]     rdata_s;
    logic            acc_s;
    logic            wr_s;
    logic            unused_data_s;

    assign unused_data_s = ^btn_data_i[31:NBTN];

    // Two-flop synchronizer on the raw pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r  <= PIN_IDLE;
            sync2_r <= PIN_IDLE;
        end else begin
            meta_r  <= btn_pins;
            sync2_r <= meta_r;
        end
    end

    assign sync_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

    for (genvar g = 0; g < NBTN; g++) begin : g_deb
        logic [23:0] cnt_r;
        logic        stable_r;

        // Debounce counter: a level must differ from stable for DEBOUNCE_CYCLES edges to be accepted
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_r    <= 24'd0;
                stable_r <= 1'b0;
            end else if (sync_s[g] == stable_r) begin
                cnt_r    <= 24'd0;
                stable_r <= stable_r;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r    <= 24'd0;
                stable_r <= sync_s[g];
            end else begin
                cnt_r    <= cnt_r + 24'd1;
                stable_r <= stable_r;
            end
        end

        assign stable_s[g] = stable_r;
    end

    assign acc_s  = btn_sel & ~ready_r;
    assign wr_s   = acc_s & btn_we;
    assign rise_s = stable_s & ~stable_d_r;

    // W1C mask for EVENTS; a same-edge press is ORed in afterwards so the set wins
    always_comb begin
        ev_clr_s = {NBTN{1'b0}};
        if (wr_s && (btn_addr == 2'd1)) begin
            ev_clr_s = btn_data_i[NBTN-1:0];
        end else begin
            ev_clr_s = {NBTN{1'b0}};
        end
    end

    assign events_nxt_s = (events_r & ~ev_clr_s) | rise_s;

    // Press edge detection and sticky event bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d_r <= {NBTN{1'b0}};
            events_r   <= {NBTN{1'b0}};
        end else begin
            stable_d_r <= stable_s;
            events_r   <= events_nxt_s;
        end
    end

`ifdef BUTTONS_IRQ_EN
    logic [NBTN-1:0] irq_en_r;
    logic            irq_r;

    // Interrupt mask register and registered level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_r <= {NBTN{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            if (wr_s && (btn_addr == 2'd2)) begin
                irq_en_r <= btn_data_i[NBTN-1:0];
            end else begin
                irq_en_r <= irq_en_r;
            end
            irq_r <= |(events_r & irq_en_r);
        end
    end

    assign btn_irq = irq_r;
`else
    assign btn_irq = 1'b0;
`endif

    // Read multiplexer; EVENTS returns the pre-update value
    always_comb begin
        rdata_s = 32'd0;
        case (btn_addr)
            2'd0:    rdata_s = 32'(stable_s);
            2'd1:    rdata_s = 32'(events_r);
`ifdef BUTTONS_IRQ_EN
            2'd2:    rdata_s = 32'(irq_en_r);
`endif
            default: rdata_s = 32'd0;
        endcase
    end

    // One-wait-state handshake; read data captured with the ready pulse and held afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r  <= 1'b0;
            data_o_r <= 32'd0;
        end else begin
            ready_r <= acc_s;
            if (acc_s) begin
                data_o_r <= rdata_s;
            end else begin
                data_o_r <= data_o_r;
            end
        end
    end

    assign btn_ready  = ready_r;
    assign btn_data_o = data_o_r;

endmodule

// File: tb/tb_buttons_in.sv
// Directed self-checking bench for buttons_in with DEBOUNCE_CYCLES=4, NBTN=2, ACTIVE_LOW=1.
// Define BUTTONS_IRQ_EN for both files to exercise the interrupt path.
module tb_buttons_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  btn_pins;
    logic        btn_sel;
    logic        btn_we;
    logic [1:0]  btn_addr;
    logic [31:0] btn_data_i;
    logic        btn_ready;
    logic [31:0] btn_data_o;
    logic        btn_irq;

    int n_checks = 0;
    int n_fail   = 0;

    buttons_in #(
        .NBTN(2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_pins(btn_pins),
        .btn_sel(btn_sel),
        .btn_we(btn_we),
        .btn_addr(btn_addr),
        .btn_data_i(btn_data_i),
        .btn_ready(btn_ready),
        .btn_data_o(btn_data_o),
        .btn_irq(btn_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete access, started at a negedge; returns at the negedge after ready drops.
    task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata);
        btn_sel    = 1'b1;
        btn_we     = we;
        btn_addr   = addr;
        btn_data_i = wdata;
        @(negedge clk);
        check_eq("bus_ready", {31'd0, btn_ready}, 32'd1);
        rdata   = btn_data_o;
        btn_sel = 1'b0;
        btn_we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, addr, 32'd0, d);
        check_eq(tag, d, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        bus(1'b1, addr, wdata, d);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        btn_pins   = 2'b11;
        btn_sel    = 1'b0;
        btn_we     = 1'b0;
        btn_addr   = 2'd0;
        btn_data_i = 32'd0;
        ticks(3);
        check_eq("rst_ready", {31'd0, btn_ready}, 32'd0);
        check_eq("rst_data", btn_data_o, 32'd0);
        check_eq("rst_irq", {31'd0, btn_irq}, 32'd0);
        reset_n = 1'b1;
        ticks(5);
        check_eq("idle_stable", {30'd0, dut.stable_s}, 32'd0);

        // Short glitch on pin0 never reaches stable
        btn_pins[0] = 1'b0;
        ticks(3);
        btn_pins[0] = 1'b1;
        ticks(8);
        rd("glitch_status", 2'd0, 32'h0);
        rd("glitch_events", 2'd1, 32'h0);

        // Clean press: stable exactly 6 edges later, event one edge after that
        btn_pins[0] = 1'b0;
        ticks(5);
        check_eq("press_stable_5", {30'd0, dut.stable_s}, 32'd0);
        ticks(1);
        check_eq("press_stable_6", {30'd0, dut.stable_s}, 32'd1);
        check_eq("press_events_6", {30'd0, dut.events_r}, 32'd0);
        ticks(1);
        check_eq("press_events_7", {30'd0, dut.events_r}, 32'd1);
        rd("press_rd_events", 2'd1, 32'h1);
        rd("press_rd_status", 2'd0, 32'h1);

        // W1C, high data bits ignored, STATUS read-only
        btn_pins[1] = 1'b0;
        ticks(8);
        rd("both_events", 2'd1, 32'h3);
        wr(2'd1, 32'h1);
        rd("w1c_events", 2'd1, 32'h2);
        wr(2'd1, 32'h4);
        rd("w1c_high_bits", 2'd1, 32'h2);
        wr(2'd0, 32'hFFFF_FFFF);
        rd("status_ro", 2'd0, 32'h3);

        // Release does not set an event; a new press coinciding with W1C wins
        btn_pins[1] = 1'b1;
        ticks(8);
        rd("release_events", 2'd1, 32'h2);
        btn_pins[1] = 1'b0;
        ticks(6);
        wr(2'd1, 32'h2);
        rd("set_wins", 2'd1, 32'h2);
        wr(2'd1, 32'h2);
        rd("cleared_events", 2'd1, 32'h0);

`ifdef BUTTONS_IRQ_EN
        wr(2'd2, 32'h1);
        rd("irq_en_rd", 2'd2, 32'h1);
        btn_pins[0] = 1'b1;
        ticks(8);
        btn_pins[0] = 1'b0;
        ticks(6);
        check_eq("irq_pre_events", {30'd0, dut.events_r}, 32'd0);
        check_eq("irq_pre", {31'd0, btn_irq}, 32'd0);
        ticks(1);
        check_eq("irq_ev_set", {30'd0, dut.events_r}, 32'd1);
        check_eq("irq_lag", {31'd0, btn_irq}, 32'd0);
        ticks(1);
        check_eq("irq_rise", {31'd0, btn_irq}, 32'd1);
        btn_sel    = 1'b1;
        btn_we     = 1'b1;
        btn_addr   = 2'd1;
        btn_data_i = 32'h1;
        @(negedge clk);
        check_eq("irq_clr_events", {30'd0, dut.events_r}, 32'd0);
        check_eq("irq_still_high", {31'd0, btn_irq}, 32'd1);
        btn_sel = 1'b0;
        btn_we  = 1'b0;
        @(negedge clk);
        check_eq("irq_fall", {31'd0, btn_irq}, 32'd0);
        btn_pins[1] = 1'b1;
        ticks(8);
        btn_pins[1] = 1'b0;
        ticks(9);
        check_eq("masked_events", {30'd0, dut.events_r}, 32'd2);
        check_eq("masked_irq", {31'd0, btn_irq}, 32'd0);
`else
        wr(2'd2, 32'h3);
        rd("addr2_zero", 2'd2, 32'h0);
        rd("addr3_zero", 2'd3, 32'h0);
        check_eq("irq_tied", {31'd0, btn_irq}, 32'd0);
`endif

        // Held select: ready on every second cycle
        btn_sel  = 1'b1;
        btn_we   = 1'b0;
        btn_addr = 2'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("held_sel_%0d", i + 1), {31'd0, btn_ready},
                     (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        check_eq("held_data", btn_data_o, 32'h3);
        btn_sel = 1'b0;
        ticks(2);
        check_eq("data_hold", btn_data_o, 32'h3);

        // Reset in the first cycle of a write aborts it
        btn_sel    = 1'b1;
        btn_we     = 1'b1;
        btn_addr   = 2'd1;
        btn_data_i = 32'h3;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", {31'd0, btn_ready}, 32'd0);
        check_eq("abort_data", btn_data_o, 32'd0);
        check_eq("abort_irq", {31'd0, btn_irq}, 32'd0);
        check_eq("abort_stable", {30'd0, dut.stable_s}, 32'd0);
        btn_sel     = 1'b0;
        btn_we      = 1'b0;
        btn_pins[1] = 1'b1;
        ticks(2);
        reset_n = 1'b1;
        ticks(6);
        check_eq("post_rst_ev_6", {30'd0, dut.events_r}, 32'd0);
        ticks(1);
        check_eq("post_rst_ev_7", {30'd0, dut.events_r}, 32'd1);
        rd("post_rst_events", 2'd1, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
